alu_issue_ctrl: RTL and testbench

- Instruction issue and writeback sequencer that drives the ALU's operand side (Cond, Op_C, Reg1, Reg2, Ld_Sh) and consumes its result (dest_reg) and condition-pass signal.
- Owns an 8x16 register file. Accepts 16-bit instruction words over a valid/ready handshake.
- Sequences each instruction through IDLE → ISSUE → WB.

---
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the ALU: owns an 8x16 register file, steps each word IDLE -> ISSUE -> WB.
// Optional performance counters are enabled with `define ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int NREGS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [1:0]  alu_cond,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_reg1,
  output logic [15:0] alu_reg2,
  output logic [6:0]  alu_ld_sh,
  input  logic [15:0] alu_result,
  input  logic        alu_cond_ok,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        halted
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_skipped
`endif
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         alu_cond_q;
  logic [3:0]         alu_op_q;
  logic [15:0]        alu_reg1_q, alu_reg2_q;
  logic [6:0]         alu_ld_sh_q;
  logic [2:0]         rd_q;
  logic               wb_valid_q;
  logic [2:0]         wb_addr_q;
  logic [15:0]        wb_data_q;
  logic [15:0]        regs_q [NREGS];
  logic               accept;
  logic               wb_fire;

  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  // Ops 0000..1010 are the only ones that produce a register result.
  assign wb_fire     = (state_q == S_WB) && alu_cond_ok && (alu_op_q <= 4'd10);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          cnt_d   = CNT_W'(ALU_LAT - 1);
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) state_d = S_WB;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WB:    state_d = (alu_op_q == 4'hF) ? S_HALT : S_IDLE;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_cond_q  <= '0;
      alu_op_q    <= '0;
      alu_reg1_q  <= '0;
      alu_reg2_q  <= '0;
      alu_ld_sh_q <= '0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_fire;
      if (accept) begin
        alu_cond_q  <= instr[15:14];
        alu_op_q    <= instr[13:10];
        rd_q        <= instr[9:7];
        alu_ld_sh_q <= instr[6:0];
        alu_reg1_q  <= regs_q[instr[9:7]];
        alu_reg2_q  <= regs_q[instr[6:4]];
      end
      if (wb_fire) begin
        wb_addr_q <= rd_q;
        wb_data_q <= alu_result;
      end
    end
  end

  // Registers must clear on reset, so the file is built from flops rather than RAM.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n)                              regs_q[gi] <= '0;
        else if (wb_fire && (rd_q == 3'(gi)))    regs_q[gi] <= alu_result;
      end
    end
  endgenerate

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_issued_q, perf_skipped_q;

  // No accept or WB can occur in HALT, so both counters freeze there naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q  <= '0;
      perf_skipped_q <= '0;
    end else begin
      if (accept)                           perf_issued_q  <= perf_issued_q + 16'd1;
      if ((state_q == S_WB) && !alu_cond_ok) perf_skipped_q <= perf_skipped_q + 16'd1;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_skipped = perf_skipped_q;
`endif

  assign alu_cond  = alu_cond_q;
  assign alu_op    = alu_op_q;
  assign alu_reg1  = alu_reg1_q;
  assign alu_reg2  = alu_reg2_q;
  assign alu_ld_sh = alu_ld_sh_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl at ALU_LAT=3; the ALU is modelled by driving alu_result/alu_cond_ok per instruction.
module tb_alu_issue_ctrl;
  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [1:0]  alu_cond;
  logic [3:0]  alu_op;
  logic [15:0] alu_reg1, alu_reg2;
  logic [6:0]  alu_ld_sh;
  logic [15:0] alu_result;
  logic        alu_cond_ok;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        halted;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_issued, perf_skipped;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_q[$];

  alu_issue_ctrl #(.ALU_LAT(LAT), .NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_cond    (alu_cond),
    .alu_op      (alu_op),
    .alu_reg1    (alu_reg1),
    .alu_reg2    (alu_reg2),
    .alu_ld_sh   (alu_ld_sh),
    .alu_result  (alu_result),
    .alu_cond_ok (alu_cond_ok),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .halted      (halted)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_skipped(perf_skipped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept log: valid && ready seen just before a rising edge is a handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) acc_q.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
    dbg_addr = a;
    #1;
    check_val(tag, dbg_data, exp);
  endtask

  // Issue one word and follow it to writeback; called and returns on a falling edge.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] res, input logic ok,
                           input logic [15:0] exp_r1, input logic [15:0] exp_r2,
                           input logic exp_wr, input logic [2:0] exp_addr,
                           input logic [15:0] exp_data, input logic exp_halt);
    int n;
    alu_result  = res;
    alu_cond_ok = ok;
    instr       = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_ready", instr_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    $display("issue instr=0x%04h result=0x%04h cond_ok=%0d", ins, res, ok);
    check_val("issue_cond",  alu_cond,  ins[15:14]);
    check_val("issue_op",    alu_op,    ins[13:10]);
    check_val("issue_ldsh",  alu_ld_sh, ins[6:0]);
    check_val("issue_reg1",  alu_reg1,  exp_r1);
    check_val("issue_reg2",  alu_reg2,  exp_r2);
    check_val("issue_ready", instr_ready, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check_val("wb_valid", wb_valid, (k == LAT + 1) && exp_wr);
      if (k <= LAT) check_val("busy_ready", instr_ready, 1'b0);
    end
    check_val("post_ready",  instr_ready, !exp_halt);
    check_val("post_halted", halted, exp_halt);
    if (exp_wr) begin
      check_val("wb_addr", wb_addr, exp_addr);
      check_val("wb_data", wb_data, exp_data);
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    alu_result  = '0;
    alu_cond_ok = 1'b0;
    dbg_addr    = '0;
    repeat (2) @(negedge clk);
    check_val("rst_ready",  instr_ready, 1'b0);
    check_val("rst_wb",     wb_valid, 1'b0);
    check_val("rst_halted", halted, 1'b0);
    check_val("rst_op",     alu_op, 4'h0);
    check_val("rst_wbdata", wb_data, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_ready", instr_ready, 1'b1);
    read_reg(3'd3, 16'h0000, "rst_r3");

    // MOVn: cond=00 op=0110 rd=3 imm7=7F
    run_instr(16'h19FF, 16'h007F, 1'b1, 16'h0, 16'h0, 1'b1, 3'd3, 16'h007F, 1'b0);
    read_reg(3'd3, 16'h007F, "mov_r3");
    // R1=5, R2=7 via MOVn
    run_instr(16'h1885, 16'h0005, 1'b1, 16'h0, 16'h0, 1'b1, 3'd1, 16'h0005, 1'b0);
    run_instr(16'h1907, 16'h0007, 1'b1, 16'h0, 16'h0, 1'b1, 3'd2, 16'h0007, 1'b0);
    // ADD rd=1 rs=2 -> 12
    run_instr(16'h00A0, 16'h000C, 1'b1, 16'd5, 16'd7, 1'b1, 3'd1, 16'h000C, 1'b0);
    read_reg(3'd1, 16'h000C, "add_r1");
    // Same ADD with the condition failing: no write, wb_* keep last value
    run_instr(16'h00A0, 16'h0099, 1'b0, 16'd12, 16'd7, 1'b0, 3'd0, 16'h0, 1'b0);
    read_reg(3'd1, 16'h000C, "skip_r1");
    check_val("skip_wbaddr_hold", wb_addr, 3'd1);
    check_val("skip_wbdata_hold", wb_data, 16'h000C);
`ifdef ALU_ISSUE_PERF_EN
    check_val("perf_issued",  perf_issued, 16'd5);
    check_val("perf_skipped", perf_skipped, 16'd1);
`endif
    // CMP rd=1 rs=2, cond_ok=1: never writes
    run_instr(16'h2CA0, 16'h0055, 1'b1, 16'd12, 16'd7, 1'b0, 3'd0, 16'h0, 1'b0);
    read_reg(3'd1, 16'h000C, "cmp_r1");
    // cond=10 op=0001 rd=rs=3: both operands carry R3
    run_instr(16'h85B0, 16'h00FE, 1'b1, 16'h007F, 16'h007F, 1'b1, 3'd3, 16'h00FE, 1'b0);
    read_reg(3'd3, 16'h00FE, "rdrs_r3");

    // Back-to-back NOPs with valid held high: accepts every LAT+2 cycles
    alu_result  = 16'hAAAA;
    alu_cond_ok = 1'b1;
    instr       = 16'h3000;
    acc_q.delete();
    instr_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    check_val("tput_count", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      check_val("tput_gap1", acc_q[1] - acc_q[0], LAT + 2);
      check_val("tput_gap2", acc_q[2] - acc_q[1], LAT + 2);
    end
    repeat (LAT + 2) @(negedge clk);
    check_val("tput_idle", instr_ready, 1'b1);

    // Reset mid-ISSUE: MOVn rd=5 imm=0x11 must be dropped
    alu_result  = 16'h0011;
    instr       = 16'h1A91;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_wb",    wb_valid, 1'b0);
    check_val("midrst_ready", instr_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_idle", instr_ready, 1'b1);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check_val("midrst_nowb", wb_valid, 1'b0);
    end
    read_reg(3'd5, 16'h0000, "midrst_r5");
    read_reg(3'd1, 16'h0000, "midrst_r1");

    // Rebuild a nonzero register, then HALT
    run_instr(16'h19FF, 16'h007F, 1'b1, 16'h0, 16'h0, 1'b1, 3'd3, 16'h007F, 1'b0);
    run_instr(16'h3C00, 16'h1234, 1'b1, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    instr_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_val("halt_stays",   halted, 1'b1);
    check_val("halt_noready", instr_ready, 1'b0);
    check_val("halt_nowb",    wb_valid, 1'b0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("unhalt_halted", halted, 1'b0);
    check_val("unhalt_ready",  instr_ready, 1'b1);
    read_reg(3'd3, 16'h0000, "unhalt_r3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
